// File: rtl/stopwatch_pkg.sv
// ============================================================================
// stopwatch_pkg : shared state type and encodings for the stopwatch controller
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // Counters are enabled while time is being accumulated, lap view included.
  function automatic logic f_run_en(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// stopwatch_ctrl_if : raw buttons in, stopwatch control outputs back
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_lap;
  logic       run_en;
  logic       hold;
  logic       clr_pulse;
  logic [1:0] state;

  modport master (
    output btn_start, btn_clear, btn_lap,
    input  run_en, hold, clr_pulse, state
  );

  modport slave (
    input  btn_start, btn_clear, btn_lap,
    output run_en, hold, clr_pulse, state
  );
endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : 2-flop synchronizer, level debouncer and press-pulse detector
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic new_clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int                 c_cnt_w    = $clog2(DB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               level_q, level_d, level_prev_q;
  logic               press_q;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;

  // The level flips on the mismatch cycle that would take the count to DB_CYCLES.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == c_cnt_last) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// stopwatch_ctrl : debounced start/clear/lap buttons driving the stopwatch FSM
// Optional lap feature enabled by defining SW_LAP_EN
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl #(
  parameter int DB_CYCLES = 20
) (
  input  logic             new_clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  import stopwatch_pkg::*;

  logic   start_ev, clear_ev, lap_ev;
  logic   hold_d;
  state_t state_q, state_d;
  logic   run_en_q, hold_q, clr_q, clr_d;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .new_clk (new_clk),
    .rst     (rst),
    .btn_i   (bus.btn_start),
    .press_o (start_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .new_clk (new_clk),
    .rst     (rst),
    .btn_i   (bus.btn_clear),
    .press_o (clear_ev)
  );

`ifdef SW_LAP_EN
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .new_clk (new_clk),
    .rst     (rst),
    .btn_i   (bus.btn_lap),
    .press_o (lap_ev)
  );
  assign hold_d = (state_d == ST_LAP);
`else
  logic lap_unused;
  assign lap_unused = bus.btn_lap;
  assign lap_ev     = 1'b0;
  assign hold_d     = 1'b0;
`endif

  // Only the highest-priority event of a cycle is considered: clear > start > lap.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (clear_ev) begin
      if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
        state_d = ST_IDLE;
        clr_d   = 1'b1;
      end
    end else if (start_ev) begin
      case (state_q)
        ST_IDLE, ST_PAUSE: state_d = ST_RUN;
        default:           state_d = ST_PAUSE;
      endcase
    end else if (lap_ev) begin
      case (state_q)
        ST_RUN:  state_d = ST_LAP;
        ST_LAP:  state_d = ST_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge new_clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      run_en_q <= 1'b0;
      hold_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_en_q <= f_run_en(state_d);
      hold_q   <= hold_d;
      clr_q    <= clr_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.run_en    = run_en_q;
  assign bus.hold      = hold_q;
  assign bus.clr_pulse = clr_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// tb_stopwatch_ctrl : directed and randomized checks against a cycle reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

  localparam int c_db    = 4;
  localparam int c_idle  = 0;
  localparam int c_run   = 1;
  localparam int c_pause = 2;
  localparam int c_lap   = 3;
`ifdef SW_LAP_EN
  localparam bit c_lap_en = 1'b1;
`else
  localparam bit c_lap_en = 1'b0;
`endif

  logic new_clk = 1'b0;
  logic rst;

  stopwatch_ctrl_if u_if ();

  stopwatch_ctrl #(.DB_CYCLES(c_db)) u_dut (
    .new_clk (new_clk),
    .rst     (rst),
    .bus     (u_if.slave)
  );

  always #5 new_clk = ~new_clk;

  int         n_checks;
  int         n_errors;
  int         cyc;
  int         clr_seen;
  logic [2:0] raw_hist[$];
  bit         lvl[3];
  int         run_len[3];
  int         due[3];
  int         m_state;
  bit         m_clr;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_hist.delete();
    for (int b = 0; b < 3; b++) begin
      lvl[b]     = 1'b0;
      run_len[b] = 0;
      due[b]     = -1;
    end
    m_state = c_idle;
    m_clr   = 1'b0;
  endtask

  // One rising edge: raw level seen two edges late, accepted after c_db
  // consecutive differing samples, acted on by the FSM two edges later.
  task automatic model_edge();
    logic [2:0] smp;
    bit         ev[3];
    cyc++;
    raw_hist.push_back({u_if.btn_lap, u_if.btn_clear, u_if.btn_start});
    smp = (raw_hist.size() >= 3) ? raw_hist[raw_hist.size()-3] : 3'b000;
    while (raw_hist.size() > 3) void'(raw_hist.pop_front());
    for (int b = 0; b < 3; b++) ev[b] = (due[b] == cyc);
    if (!c_lap_en) ev[2] = 1'b0;

    m_clr = 1'b0;
    if (ev[1]) begin
      if (m_state == c_idle || m_state == c_pause) begin
        m_state = c_idle;
        m_clr   = 1'b1;
      end
    end else if (ev[0]) begin
      m_state = (m_state == c_run || m_state == c_lap) ? c_pause : c_run;
    end else if (ev[2]) begin
      if (m_state == c_run)      m_state = c_lap;
      else if (m_state == c_lap) m_state = c_run;
    end

    for (int b = 0; b < 3; b++) begin
      if (smp[b] != lvl[b]) begin
        run_len[b]++;
        if (run_len[b] == c_db) begin
          lvl[b]     = smp[b];
          run_len[b] = 0;
          if (smp[b]) due[b] = cyc + 2;
        end
      end else begin
        run_len[b] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge new_clk);
    model_edge();
    #1;
    check_val("state", u_if.state, m_state);
    check_val("run_en", u_if.run_en, (m_state == c_run || m_state == c_lap));
    check_val("hold", u_if.hold, (m_state == c_lap));
    check_val("clr_pulse", u_if.clr_pulse, m_clr);
    if (u_if.clr_pulse) clr_seen++;
  endtask

  task automatic drive(input logic [2:0] b);
    u_if.btn_start = b[0];
    u_if.btn_clear = b[1];
    u_if.btn_lap   = b[2];
  endtask

  task automatic press(input logic [2:0] b, input int hi, input int lo);
    drive(b);
    repeat (hi) step();
    drive(3'b000);
    repeat (lo) step();
  endtask

  // Called one time unit after an edge; reset must act without a clock edge.
  task automatic reset_pulse();
    rst = 1'b0;
    #1;
    check_val("rst_state", u_if.state, c_idle);
    check_val("rst_run_en", u_if.run_en, 1'b0);
    check_val("rst_hold", u_if.hold, 1'b0);
    check_val("rst_clr_pulse", u_if.clr_pulse, 1'b0);
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    int trans;
    logic [1:0] prev;
    logic [2:0] mask;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    clr_seen = 0;
    rst      = 1'b0;
    drive(3'b000);
    model_reset();
    @(posedge new_clk);
    #1;
    reset_pulse();
    repeat (3) step();

    // Start held 20 cycles: one transition, DB+4 edges after the press.
    lat   = -1;
    trans = 0;
    prev  = u_if.state;
    drive(3'b001);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (lat < 0 && u_if.run_en) lat = i;
      if (u_if.state != prev) trans++;
      prev = u_if.state;
    end
    check_val("start_latency", lat, c_db + 4);
    check_val("start_transitions", trans, 1);
    drive(3'b000);
    repeat (10) step();

    // Short glitches from IDLE must never be accepted.
    reset_pulse();
    repeat (3) step();
    repeat (5) press(3'b001, c_db - 1, 3);
    check_val("glitch_state", u_if.state, c_idle);
    check_val("glitch_run_en", u_if.run_en, 1'b0);

    // Lap enters and leaves the held display (ignored when the feature is off).
    press(3'b001, 6, 8);
    check_val("run_state", u_if.state, c_run);
    press(3'b100, 6, 8);
    check_val("lap_state", u_if.state, c_lap_en ? c_lap : c_run);
    check_val("lap_hold", u_if.hold, c_lap_en);
    check_val("lap_run_en", u_if.run_en, 1'b1);
    press(3'b100, 6, 8);
    check_val("unlap_state", u_if.state, c_run);
    check_val("unlap_hold", u_if.hold, 1'b0);

    // Pause then clear.
    press(3'b001, 6, 8);
    check_val("pause_state", u_if.state, c_pause);
    clr_seen = 0;
    press(3'b010, 6, 8);
    check_val("clear_state", u_if.state, c_idle);
    check_val("clear_run_en", u_if.run_en, 1'b0);
    check_val("clear_pulse_count", clr_seen, 1);

    // Start and clear together in PAUSE: clear wins.
    press(3'b001, 6, 8);
    press(3'b001, 6, 8);
    check_val("pause2_state", u_if.state, c_pause);
    clr_seen = 0;
    press(3'b011, 6, 8);
    check_val("tie_state", u_if.state, c_idle);
    check_val("tie_pulse_count", clr_seen, 1);

    // Reset mid-debounce from RUN, start held through release.
    press(3'b001, 6, 8);
    drive(3'b001);
    repeat (3) step();
    reset_pulse();
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (lat < 0 && u_if.run_en) lat = i;
    end
    check_val("held_rst_latency", lat, c_db + 4);
    drive(3'b000);
    repeat (10) step();

    // Randomized button traffic.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 7) == 0) mask = 3'($urandom_range(1, 7));
      else                           mask = 3'(1 << $urandom_range(0, 2));
      press(mask, $urandom_range(1, 9), $urandom_range(1, 9));
      if ($urandom_range(0, 39) == 0) reset_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 20, number of consecutive new_clk cycles a synchronized button level must differ from its debounced level before being accepted (>=2).
REQ-002 SHALL have port new_clk  input  1  divided stopwatch clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port btn_start  input  1  raw start/stop button, active-high, asynchronous to new_clk.
REQ-005 SHALL have port btn_clear  input  1  raw clear button, active-high, asynchronous.
REQ-006 SHALL have port btn_lap  input  1  raw lap button, active-high, asynchronous.
REQ-007 SHALL have port run_en  output  1  counter enable, gated with new_clk downstream.
REQ-008 SHALL have port hold  output  1  freeze display digits while counters keep running.
REQ-009 SHALL have port clr_pulse  output  1  one-cycle counter clear request.
REQ-010 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Debounce: per-button counter SHALL increment while synchronized level != debounced level, clear to 0 when equal; debounced level SHALL take the synchronized value on the cycle the counter would reach DB_CYCLES, counter then 0.
REQ-013 Mismatch runs shorter than DB_CYCLES cycles SHALL leave the debounced level unchanged.
REQ-014 A press event SHALL be a registered one-cycle pulse on each 0->1 debounced transition; release SHALL produce no event; held buttons SHALL produce exactly one event.
REQ-015 FSM states SHALL be IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
REQ-016 IDLE: start->RUN; clear->IDLE with clr_pulse; lap ignored.
REQ-017 RUN: start->PAUSE; lap->LAP; clear ignored.
REQ-018 LAP: lap->RUN; start->PAUSE; clear ignored.
REQ-019 PAUSE: start->RUN; clear->IDLE with clr_pulse; lap ignored.
REQ-020 Simultaneous events in one cycle SHALL be resolved by priority clear > start > lap; only the winner acts, others discarded.
REQ-021 run_en SHALL be 1 exactly in RUN and LAP; hold SHALL be 1 exactly in LAP; all outputs registered, decoded from next state.
REQ-022 clr_pulse SHALL be high for exactly one cycle, coincident with the state update of the accepting clear.
REQ-023 Latency from a raw edge held stable to output change SHALL be DB_CYCLES+4 rising edges of new_clk (2 sync + DB_CYCLES debounce + 1 edge + 1 FSM).

Reset
REQ-024 On rst low, asynchronously: state=IDLE, run_en=0, hold=0, clr_pulse=0, synchronizers=0, debounced levels=0, counters=0.
REQ-025 Reset mid-debounce or mid-operation SHALL discard partial counts; a button held through reset release SHALL produce one event after DB_CYCLES+4 edges.

Configuration
REQ-026 With macro SW_LAP_EN defined, lap behaviour SHALL be as REQ-017/018/021.
REQ-027 Without SW_LAP_EN, btn_lap SHALL remain a port but be ignored, LAP unreachable, hold tied 0, lap debouncer not instantiated.

Structure
REQ-028 Package stopwatch_pkg SHALL hold the state typedef and the four encodings.
REQ-029 Sub-module btn_debounce (synchronizer, debounce counter, press pulse; parameter DB_CYCLES) SHALL be instantiated per button.

Verification (DB_CYCLES=4)
REQ-030 Reset, press start held 20 cycles -> run_en 1 and state 01 exactly 8 edges after press, single transition.
REQ-031 start glitches of 3 cycles high repeatedly -> state stays 00, no outputs change.
REQ-032 RUN, press lap -> hold 1, run_en 1, state 11; press lap again -> hold 0, state 01.
REQ-033 RUN, press start -> PAUSE; press clear -> clr_pulse high exactly 1 cycle, state 00, run_en 0.
REQ-034 PAUSE, start and clear pressed same cycle -> clear wins: state 00, clr_pulse 1 cycle.
REQ-035 Without SW_LAP_EN, RUN, press lap -> state stays 01, hold 0; rst low mid-debounce -> all outputs 0 immediately.
